// File: rtl/tensor_core_pkg.sv
// Shared types and range helpers for the parametrised tensor core.
// Wide values are carried at WIDE_W bits so one helper serves every element width.
package tensor_core_pkg;

    localparam int unsigned WIDE_W = 64;

    typedef enum logic [2:0] {
        OP_MATMUL    = 3'b000,
        OP_ADD       = 3'b001,
        OP_RELU      = 3'b010,
        OP_SUB       = 3'b011,
        OP_TRANSPOSE = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic signed [WIDE_W-1:0] range_hi(input int unsigned width);
        return $signed((WIDE_W'(1) << (width - 1)) - WIDE_W'(1));
    endfunction

    function automatic logic out_of_range(input logic signed [WIDE_W-1:0] value,
                                          input int unsigned width);
        logic signed [WIDE_W-1:0] hi;
        hi = range_hi(width);
        // ~hi is -hi-1, the most negative representable value
        return (value > hi) || (value < ~hi);
    endfunction

    function automatic logic [WIDE_W-1:0] fit_range(input logic signed [WIDE_W-1:0] value,
                                                    input int unsigned width,
                                                    input logic saturate);
        logic signed [WIDE_W-1:0] hi;
        hi = range_hi(width);
        if (saturate && (value > hi)) begin
            return hi;
        end
        if (saturate && (value < ~hi)) begin
            return ~hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/param_tensor_core_if.sv
// Sequencer-facing bus of the tensor core: start/op request, operand matrices and
// result/status returned by the core.
interface param_tensor_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 3
);
    logic                         start_in;
    logic [2:0]                   op_select_in;
    logic signed [DATA_WIDTH-1:0] input1_in  [DIM][DIM];
    logic signed [DATA_WIDTH-1:0] input2_in  [DIM][DIM];
    logic signed [DATA_WIDTH-1:0] result_out [DIM][DIM];
    logic                         busy_out;
    logic                         done_out;
    logic                         overflow_out;

    modport master (
        output start_in, op_select_in, input1_in, input2_in,
        input  result_out, busy_out, done_out, overflow_out
    );

    modport slave (
        input  start_in, op_select_in, input1_in, input2_in,
        output result_out, busy_out, done_out, overflow_out
    );
endinterface

// File: rtl/tensor_core_dot_product.sv
// Signed DIM-term dot product at full precision.
// Latency: combinational. Backpressure: none.
// Accumulator carries $clog2(DIM) guard bits so the sum never wraps.
module tensor_core_dot_product #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 3
) (
    input  logic signed [DATA_WIDTH-1:0]                 row_a [DIM],
    input  logic signed [DATA_WIDTH-1:0]                 col_b [DIM],
    output logic signed [2*DATA_WIDTH+$clog2(DIM)-1:0]   dot_sum
);
    localparam int ACC_W = 2*DATA_WIDTH + $clog2(DIM);

    always_comb begin
        logic signed [2*DATA_WIDTH-1:0] prod;
        prod    = '0;
        dot_sum = '0;
        for (int k = 0; k < DIM; k++) begin
            prod    = row_a[k] * col_b[k];
            dot_sum = dot_sum + ACC_W'(prod);
        end
    end
endmodule

// File: rtl/param_tensor_core.sv
// DIM x DIM matmul/add/sub/ReLU/transpose engine writing one result element per clock.
// Latency: DIM*DIM+2 cycles accept-to-accept. Backpressure: start ignored unless idle.
// Operands are latched on accept so the source may change during the run.
module param_tensor_core
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 3,
    parameter bit SATURATE   = 1'b1
) (
    input  logic               clock_in,
    input  logic               reset_n_in,
    param_tensor_core_if.slave bus
);
    localparam int ACC_W = 2*DATA_WIDTH + $clog2(DIM);
    localparam int RC_W  = $clog2(DIM);

    state_e state_q, state_d;
    op_e    op_q;
    logic   ovf_q;
    logic [RC_W-1:0] row_q, col_q;

    logic signed [DATA_WIDTH-1:0] a_q   [DIM][DIM];
    logic signed [DATA_WIDTH-1:0] b_q   [DIM][DIM];
    logic signed [DATA_WIDTH-1:0] res_q [DIM][DIM];

    logic signed [DATA_WIDTH-1:0] row_sel [DIM];
    logic signed [DATA_WIDTH-1:0] col_sel [DIM];
    logic signed [ACC_W-1:0]      dot_sum;

    logic signed [DATA_WIDTH-1:0] a_el, b_el, elem_raw, elem_val;
    logic signed [DATA_WIDTH:0]   add_w, sub_w;
    logic signed [WIDE_W-1:0]     wide;
    logic                         checked, elem_ovf;

    logic accept, op_legal, last_elem;

    assign op_legal  = (bus.op_select_in <= 3'd4);
    assign accept    = (state_q == IDLE) && bus.start_in;
    assign last_elem = (row_q == RC_W'(DIM-1)) && (col_q == RC_W'(DIM-1));

    always_comb begin
        for (int k = 0; k < DIM; k++) begin
            row_sel[k] = a_q[row_q][k];
            col_sel[k] = b_q[k][col_q];
        end
    end

    tensor_core_dot_product #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIM        (DIM)
    ) u_dot (
        .row_a   (row_sel),
        .col_b   (col_sel),
        .dot_sum (dot_sum)
    );

    // Element datapath: only the arithmetic ops go through the range check.
    always_comb begin
        a_el     = a_q[row_q][col_q];
        b_el     = b_q[row_q][col_q];
        add_w    = (DATA_WIDTH+1)'(a_el) + (DATA_WIDTH+1)'(b_el);
        sub_w    = (DATA_WIDTH+1)'(a_el) - (DATA_WIDTH+1)'(b_el);
        wide     = '0;
        checked  = 1'b0;
        elem_raw = '0;
        case (op_q)
            OP_MATMUL: begin
                wide    = WIDE_W'(dot_sum);
                checked = 1'b1;
            end
            OP_ADD: begin
                wide    = WIDE_W'(add_w);
                checked = 1'b1;
            end
            OP_SUB: begin
                wide    = WIDE_W'(sub_w);
                checked = 1'b1;
            end
            OP_RELU:      elem_raw = a_el[DATA_WIDTH-1] ? '0 : a_el;
            OP_TRANSPOSE: elem_raw = a_q[col_q][row_q];
            default:      elem_raw = '0;
        endcase
        elem_ovf = checked && out_of_range(wide, DATA_WIDTH);
        elem_val = checked ? DATA_WIDTH'(fit_range(wide, DATA_WIDTH, SATURATE)) : elem_raw;
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_in) state_d = op_legal ? RUN : DONE;
            RUN:     if (last_elem) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            res_q <= '{default: '0};
            op_q  <= OP_MATMUL;
            ovf_q <= 1'b0;
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            a_q   <= bus.input1_in;
            b_q   <= bus.input2_in;
            op_q  <= op_e'(bus.op_select_in);
            ovf_q <= 1'b0;
            row_q <= '0;
            col_q <= '0;
        end else if (state_q == RUN) begin
            res_q[row_q][col_q] <= elem_val;
            if (elem_ovf) begin
                ovf_q <= 1'b1;
            end
            if (col_q == RC_W'(DIM-1)) begin
                col_q <= '0;
                row_q <= row_q + RC_W'(1);
            end else begin
                col_q <= col_q + RC_W'(1);
            end
        end
    end

    assign bus.result_out   = res_q;
    assign bus.busy_out     = (state_q == RUN);
    assign bus.done_out     = (state_q == DONE);
    assign bus.overflow_out = ovf_q;

endmodule

// File: tb/tb_param_tensor_core.sv
// Directed bench for param_tensor_core: a saturating and a wrapping instance run the
// same vector table, then hand-written held-start, abort and reset sequences.
module tb_param_tensor_core;
    typedef logic [2:0][2:0][7:0] mat_t;

    typedef struct packed {
        logic [2:0] op;
        mat_t       a;
        mat_t       b;
        mat_t       exp_s;
        mat_t       exp_w;
        logic       exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    param_tensor_core_if #(.DATA_WIDTH(8), .DIM(3)) bus_s ();
    param_tensor_core_if #(.DATA_WIDTH(8), .DIM(3)) bus_w ();

    param_tensor_core #(.DATA_WIDTH(8), .DIM(3), .SATURATE(1'b1)) dut_s (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus_s)
    );

    param_tensor_core #(.DATA_WIDTH(8), .DIM(3), .SATURATE(1'b0)) dut_w (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus_w)
    );

    function automatic mat_t mk(input int e0, input int e1, input int e2,
                                input int e3, input int e4, input int e5,
                                input int e6, input int e7, input int e8);
        int   t [9];
        mat_t m;
        t = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m[r][c] = t[r*3+c][7:0];
        return m;
    endfunction

    function automatic mat_t fill(input int x);
        return mk(x, x, x, x, x, x, x, x, x);
    endfunction

    function automatic mat_t res_s();
        mat_t m;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m[r][c] = bus_s.result_out[r][c];
        return m;
    endfunction

    function automatic mat_t res_w();
        mat_t m;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m[r][c] = bus_w.result_out[r][c];
        return m;
    endfunction

    task automatic drive(input logic [2:0] op, input mat_t a, input mat_t b, input logic st);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                bus_s.input1_in[r][c] = a[r][c];
                bus_s.input2_in[r][c] = b[r][c];
                bus_w.input1_in[r][c] = a[r][c];
                bus_w.input2_in[r][c] = b[r][c];
            end
        end
        bus_s.op_select_in = op;
        bus_w.op_select_in = op;
        bus_s.start_in     = st;
        bus_w.start_in     = st;
    endtask

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " res_s"}, res_s(), '0);
        check({tag, " res_w"}, res_w(), '0);
        check({tag, " flags"}, {bus_s.busy_out, bus_s.done_out, bus_s.overflow_out,
                                bus_w.busy_out, bus_w.done_out, bus_w.overflow_out}, '0);
    endtask

    // One operation: operands are zeroed right after accept to prove they were latched.
    task automatic run_op(input vec_t v, input string tag);
        int busy_cnt;
        bit seen;
        busy_cnt = 0;
        seen     = 1'b0;
        @(negedge clk);
        drive(v.op, v.a, v.b, 1'b1);
        @(negedge clk);
        drive(3'd0, '0, '0, 1'b0);
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus_s.done_out) begin
                seen = 1'b1;
            end else begin
                if (bus_s.busy_out) busy_cnt++;
                @(negedge clk);
            end
        end
        check({tag, " done"}, {seen, bus_w.done_out, bus_s.busy_out}, {1'b1, 1'b1, 1'b0});
        check({tag, " busy_cycles"}, busy_cnt, (v.op <= 3'd4) ? 9 : 0);
        check({tag, " res_s"}, res_s(), v.exp_s);
        check({tag, " res_w"}, res_w(), v.exp_w);
        check({tag, " ovf"}, {bus_s.overflow_out, bus_w.overflow_out}, {v.exp_ovf, v.exp_ovf});
        @(negedge clk);
        check({tag, " done_fall"}, {bus_s.done_out, bus_w.done_out}, 2'b00);
    endtask

    vec_t vecs [10];
    mat_t ident, b19, a_relu;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        int busy_cnt;

        ident  = mk(1, 0, 0, 0, 1, 0, 0, 0, 1);
        b19    = mk(1, 2, 3, 4, 5, 6, 7, 8, 9);
        a_relu = mk(-5, 3, 0, 7, -1, 2, -128, 127, 4);

        vecs[0] = '{op: 3'd0, a: ident, b: b19, exp_s: b19, exp_w: b19, exp_ovf: 1'b0};
        vecs[1] = '{op: 3'd1, a: fill(100), b: fill(100), exp_s: fill(127), exp_w: fill(-56), exp_ovf: 1'b1};
        vecs[2] = '{op: 3'd1, a: fill(1), b: fill(1), exp_s: fill(2), exp_w: fill(2), exp_ovf: 1'b0};
        vecs[3] = '{op: 3'd0, a: fill(-128), b: fill(-128), exp_s: fill(127), exp_w: fill(0), exp_ovf: 1'b1};
        vecs[4] = '{op: 3'd2, a: a_relu, b: fill(55),
                    exp_s: mk(0, 3, 0, 7, 0, 2, 0, 127, 4), exp_w: mk(0, 3, 0, 7, 0, 2, 0, 127, 4), exp_ovf: 1'b0};
        vecs[5] = '{op: 3'd4, a: a_relu, b: fill(0),
                    exp_s: mk(-5, 7, -128, 3, -1, 127, 0, 2, 4), exp_w: mk(-5, 7, -128, 3, -1, 127, 0, 2, 4), exp_ovf: 1'b0};
        vecs[6] = '{op: 3'd3, a: mk(10, -100, 127, 0, 0, 0, 5, 5, 5), b: mk(3, 100, -1, 0, 0, 0, -5, 5, 6),
                    exp_s: mk(7, -128, 127, 0, 0, 0, 10, 0, -1), exp_w: mk(7, 56, -128, 0, 0, 0, 10, 0, -1), exp_ovf: 1'b1};
        vecs[7] = '{op: 3'd7, a: fill(9), b: fill(9),
                    exp_s: mk(7, -128, 127, 0, 0, 0, 10, 0, -1), exp_w: mk(7, 56, -128, 0, 0, 0, 10, 0, -1), exp_ovf: 1'b0};
        vecs[8] = '{op: 3'd1, a: mk(100, -100, 64, -64, 0, 1, -1, 27, -28), b: mk(27, -28, 63, -64, 0, 0, 0, 100, -100),
                    exp_s: mk(127, -128, 127, -128, 0, 1, -1, 127, -128), exp_w: mk(127, -128, 127, -128, 0, 1, -1, 127, -128), exp_ovf: 1'b0};
        vecs[9] = '{op: 3'd0, a: mk(1, 2, 0, 0, 1, -1, 3, 0, 2), b: mk(2, -1, 0, 1, 1, 1, 0, 3, -2),
                    exp_s: mk(4, 1, 2, 1, -2, 3, 6, 3, -4), exp_w: mk(4, 1, 2, 1, -2, 3, 6, 3, -4), exp_ovf: 1'b0};

        drive(3'd0, '0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("initial_reset");

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start held high through RUN with different op/operands: must not restart
        @(negedge clk);
        drive(3'd0, ident, b19, 1'b1);
        @(negedge clk);
        drive(3'd1, fill(50), fill(50), 1'b1);
        dones    = 0;
        busy_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus_s.done_out) begin
                dones++;
                drive(3'd1, fill(50), fill(50), 1'b0);
            end
            if (bus_s.busy_out) busy_cnt++;
            @(negedge clk);
        end
        drive(3'd0, '0, '0, 1'b0);
        check("held_start dones", dones, 1);
        check("held_start busy_cycles", busy_cnt, 9);
        check("held_start result", res_s(), b19);
        check("held_start idle", {bus_s.busy_out, bus_s.done_out}, 2'b00);

        // abort after element 4 of B19+B19: old elements past index 4 still hold B19
        @(negedge clk);
        drive(3'd1, b19, b19, 1'b1);
        @(negedge clk);
        drive(3'd0, '0, '0, 1'b0);
        repeat (5) @(negedge clk);
        check("abort partial", {bus_s.result_out[1][1], bus_s.result_out[1][2]}, {8'd10, 8'd6});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("abort_reset");
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus_s.done_out || bus_w.done_out || bus_s.busy_out) dones++;
            @(negedge clk);
        end
        check("abort no_done", dones, 0);

        run_op(vecs[1], "pre_reset");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("final_reset");
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
